// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader.
// Optional checksum stage: define IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERROR
    } state_t;

    localparam int   WORD_BYTES   = 4;
    localparam logic RESET_ACTIVE = 1'b0;

endpackage

// File: rtl/imem_word_assembler.sv
// Little-endian byte-to-word lane register for the loader.
// Uses IMEM_LOADER_CHECKSUM_EN only indirectly via the loader top.
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    load,
    input  logic [7:0]              byte_in,
    output logic [8*WORD_BYTES-1:0] word,
    output logic                    word_full
);

    localparam int IDX_W = $clog2(WORD_BYTES);

    logic [IDX_W-1:0] idx;

    // High when the byte being loaded completes the word.
    assign word_full = load && (idx == IDX_W'(WORD_BYTES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (reset == RESET_ACTIVE) begin
            idx  <= '0;
            word <= '0;
        end else if (clear) begin
            idx  <= '0;
            word <= '0;
        end else if (load) begin
            word[8*idx +: 8] <= byte_in;
            idx              <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte program into instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  words_written
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_LAST = CHK;
`else
    localparam state_t AFTER_LAST = DONE;
`endif

    state_t            state, state_n;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_n;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       word;
    logic              word_full;
    logic              accept;
    logic              start_ok;
    logic              len_zero;
    logic              len_big;
    logic              last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    assign accept    = byte_valid && byte_ready;
    assign start_ok  = start &&
        (state == IDLE || state == DONE || state == ERROR);
    assign len_n     = LEN_W'({byte_in, len_q[7:0]});
    assign len_zero  = (len_n == '0);
    assign len_big   = 32'(len_n) > DEPTH;
    assign last_word = (words_written + 1'b1) == len_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = word;

    imem_word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .load      (accept && state == DATA),
        .byte_in   (byte_in),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (reset == RESET_ACTIVE) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, DONE, ERROR: begin
                if (start) state_n = LEN_LO;
            end
            LEN_LO: begin
                if (accept) state_n = LEN_HI;
            end
            LEN_HI: begin
                if (accept) begin
                    if (len_zero)     state_n = AFTER_LAST;
                    else if (len_big) state_n = ERROR;
                    else              state_n = DATA;
                end
            end
            DATA: begin
                if (word_full) state_n = WRITE;
            end
            WRITE: begin
                state_n = last_word ? AFTER_LAST : DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept)
                    state_n = (byte_in == csum_q) ? DONE : ERROR;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        cpu_reset  = 1'b1;
        unique case (state)
            IDLE: busy = 1'b0;
            LEN_LO, LEN_HI, DATA, CHK: byte_ready = 1'b1;
            WRITE: mem_we = 1'b1;
            DONE: begin
                busy      = 1'b0;
                done      = 1'b1;
                cpu_reset = 1'b0;
            end
            ERROR: begin
                busy  = 1'b0;
                error = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (reset == RESET_ACTIVE) begin
            len_q         <= '0;
            addr_q        <= '0;
            words_written <= '0;
        end else begin
            if (start_ok) begin
                len_q         <= '0;
                addr_q        <= '0;
                words_written <= '0;
            end
            if (state == LEN_LO && accept)
                len_q <= LEN_W'(byte_in);
            if (state == LEN_HI && accept)
                len_q <= len_n;
            if (state == WRITE) begin
                addr_q        <= addr_q + 1'b1;
                words_written <= words_written + 1'b1;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (reset == RESET_ACTIVE) begin
            csum_q <= '0;
        end else if (start_ok) begin
            csum_q <= '0;
        end else if (state == DATA && accept) begin
            csum_q <= csum_q ^ byte_in;
        end
    end
`endif

endmodule
